// File: rtl/bit_timing_fsm.sv
// Bit timing sequencer: walks SYNC/PROP/PS1/PS2 on tq ticks, applies hard sync
// and a single resynchronisation per bit, and emits registered timing pulses.
module bit_timing_fsm (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tq_tick,
  input  logic [3:0] prop_seg,
  input  logic [3:0] phase_segment_1,
  input  logic [3:0] phase_segment_2,
  input  logic       hard_sync_request,
  input  logic       resync_required,
  input  logic [3:0] resync_adjustment,
  input  logic       resync_direction,
  output logic [1:0] current_segment,
  output logic [4:0] quanta_counter,
  output logic       sample_point,
  output logic       transmit_point,
  output logic       bit_boundary
);

  localparam int unsigned SEG_W = 2;
  localparam int unsigned QC_W  = 5;
  localparam int unsigned LEN_W = 6;

  localparam logic [1:0] SEG_SYNC = 2'b00;
  localparam logic [1:0] SEG_PROP = 2'b01;
  localparam logic [1:0] SEG_PS1  = 2'b10;
  localparam logic [1:0] SEG_PS2  = 2'b11;

  logic [SEG_W-1:0] seg_nxt;
  logic [QC_W-1:0]  qc_nxt;
  logic [QC_W-1:0]  ext1;
  logic [QC_W-1:0]  ext1_nxt;
  logic [QC_W-1:0]  short2;
  logic [QC_W-1:0]  short2_nxt;
  logic             resync_done;
  logic             done_nxt;
  logic             sp_nxt;
  logic             tp_nxt;
  logic             bb_nxt;

  logic [LEN_W-1:0] prop_len;
  logic [LEN_W-1:0] ps1_len;
  logic [LEN_W-1:0] ps2_base;
  logic [LEN_W-1:0] ps2_short;
  logic [LEN_W-1:0] ps2_len;
  logic [LEN_W-1:0] qc_inc;
  logic [LEN_W-1:0] seg_len;
  logic             seg_end;

  // Segment length from live config plus the registered resync adjustments
  always_comb begin
    prop_len  = (prop_seg == 4'd0) ? LEN_W'(1) : LEN_W'(prop_seg);
    ps1_len   = ((phase_segment_1 == 4'd0) ? LEN_W'(1) : LEN_W'(phase_segment_1))
                + LEN_W'(ext1);
    ps2_base  = (phase_segment_2 == 4'd0) ? LEN_W'(1) : LEN_W'(phase_segment_2);
    ps2_short = (ps2_base > LEN_W'(short2)) ? (ps2_base - LEN_W'(short2)) : LEN_W'(0);
    qc_inc    = LEN_W'(quanta_counter) + LEN_W'(1);
    // A shortened PS2 never ends before the tick already in progress
    ps2_len   = (ps2_short > qc_inc) ? ps2_short : qc_inc;
    seg_len   = LEN_W'(1);
    case (current_segment)
      SEG_SYNC: seg_len = LEN_W'(1);
      SEG_PROP: seg_len = prop_len;
      SEG_PS1:  seg_len = ps1_len;
      SEG_PS2:  seg_len = ps2_len;
      default:  seg_len = LEN_W'(1);
    endcase
    seg_end = (qc_inc >= seg_len);
  end

  // Next-state, resync bookkeeping and pulse generation
  always_comb begin
    seg_nxt    = current_segment;
    qc_nxt     = quanta_counter;
    ext1_nxt   = ext1;
    short2_nxt = short2;
    done_nxt   = resync_done;
    sp_nxt     = 1'b0;
    tp_nxt     = 1'b0;
    bb_nxt     = 1'b0;
    if (enable) begin
      if (hard_sync_request) begin
        seg_nxt    = SEG_SYNC;
        qc_nxt     = '0;
        ext1_nxt   = '0;
        short2_nxt = '0;
        done_nxt   = 1'b0;
      end else begin
        if (resync_required && !resync_done) begin
          if (!resync_direction &&
              (current_segment == SEG_PROP || current_segment == SEG_PS1)) begin
            ext1_nxt = QC_W'(resync_adjustment);
            done_nxt = 1'b1;
          end else if (resync_direction && current_segment == SEG_PS2) begin
            short2_nxt = QC_W'(resync_adjustment);
            done_nxt   = 1'b1;
          end
        end
        if (tq_tick) begin
          if (seg_end) begin
            qc_nxt = '0;
            case (current_segment)
              SEG_SYNC: begin
                seg_nxt = SEG_PROP;
                tp_nxt  = 1'b1;
              end
              SEG_PROP: seg_nxt = SEG_PS1;
              SEG_PS1: begin
                seg_nxt = SEG_PS2;
                sp_nxt  = 1'b1;
              end
              default: begin
                seg_nxt    = SEG_SYNC;
                bb_nxt     = 1'b1;
                ext1_nxt   = '0;
                short2_nxt = '0;
                done_nxt   = 1'b0;
              end
            endcase
          end else begin
            qc_nxt = quanta_counter + QC_W'(1);
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      current_segment <= SEG_SYNC;
      quanta_counter  <= '0;
      ext1            <= '0;
      short2          <= '0;
      resync_done     <= 1'b0;
      sample_point    <= 1'b0;
      transmit_point  <= 1'b0;
      bit_boundary    <= 1'b0;
    end else begin
      current_segment <= seg_nxt;
      quanta_counter  <= qc_nxt;
      ext1            <= ext1_nxt;
      short2          <= short2_nxt;
      resync_done     <= done_nxt;
      sample_point    <= sp_nxt;
      transmit_point  <= tp_nxt;
      bit_boundary    <= bb_nxt;
    end
  end

endmodule

// File: tb/tb_bit_timing_fsm.sv
// Directed bench for bit_timing_fsm: nominal bit, zero-length config, resync
// lengthen/shorten, repeated resync, hard sync, enable freeze and reset.
module tb_bit_timing_fsm;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       tq_tick;
  logic [3:0] prop_seg;
  logic [3:0] phase_segment_1;
  logic [3:0] phase_segment_2;
  logic       hard_sync_request;
  logic       resync_required;
  logic [3:0] resync_adjustment;
  logic       resync_direction;
  logic [1:0] current_segment;
  logic [4:0] quanta_counter;
  logic       sample_point;
  logic       transmit_point;
  logic       bit_boundary;

  int checks = 0;
  int errors = 0;

  bit_timing_fsm dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .tq_tick           (tq_tick),
    .prop_seg          (prop_seg),
    .phase_segment_1   (phase_segment_1),
    .phase_segment_2   (phase_segment_2),
    .hard_sync_request (hard_sync_request),
    .resync_required   (resync_required),
    .resync_adjustment (resync_adjustment),
    .resync_direction  (resync_direction),
    .current_segment   (current_segment),
    .quanta_counter    (quanta_counter),
    .sample_point      (sample_point),
    .transmit_point    (transmit_point),
    .bit_boundary      (bit_boundary)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] p, input logic [3:0] s1, input logic [3:0] s2);
    reset_n           = 1'b0;
    enable            = 1'b0;
    tq_tick           = 1'b0;
    hard_sync_request = 1'b0;
    resync_required   = 1'b0;
    resync_adjustment = 4'd0;
    resync_direction  = 1'b0;
    prop_seg          = p;
    phase_segment_1   = s1;
    phase_segment_2   = s2;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Expected {segment, counter, sp, tp, bb} after tick k of a 2/3/3 bit
  function automatic logic [9:0] exp_nom(input int k);
    logic [9:0] e;
    case (((k - 1) % 9) + 1)
      1:       e = {2'b01, 5'd0, 3'b010};
      2:       e = {2'b01, 5'd1, 3'b000};
      3:       e = {2'b10, 5'd0, 3'b000};
      4:       e = {2'b10, 5'd1, 3'b000};
      5:       e = {2'b10, 5'd2, 3'b000};
      6:       e = {2'b11, 5'd0, 3'b100};
      7:       e = {2'b11, 5'd1, 3'b000};
      8:       e = {2'b11, 5'd2, 3'b000};
      default: e = {2'b00, 5'd0, 3'b001};
    endcase
    return e;
  endfunction

  task automatic test_reset();
    logic [9:0] obs;
    do_reset(4'd2, 4'd3, 4'd3);
    reset_n = 1'b0;
    step();
    obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 10'd0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [9:0] obs;
    do_reset(4'd2, 4'd3, 4'd3);
    enable  = 1'b1;
    tq_tick = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
      checks++;
      if (obs !== exp_nom(k)) begin
        errors++;
        $display("FAIL nominal_tick%0d: got %h expected %h", k, obs, exp_nom(k));
      end
    end
  endtask

  task automatic test_zero_lengths();
    logic [2:0] obs;
    logic [2:0] exp;
    do_reset(4'd0, 4'd0, 4'd0);
    enable  = 1'b1;
    tq_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      obs = {sample_point, transmit_point, bit_boundary};
      exp = {k % 4 == 3, k % 4 == 1, k % 4 == 0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_len_tick%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_lengthen();
    logic [2:0] obs;
    logic [2:0] exp;
    do_reset(4'd2, 4'd3, 4'd3);
    enable            = 1'b1;
    tq_tick           = 1'b1;
    resync_direction  = 1'b0;
    resync_adjustment = 4'd2;
    for (int k = 1; k <= 20; k++) begin
      resync_required = (k == 2);
      step();
      obs = {sample_point, transmit_point, bit_boundary};
      exp = {k == 8 || k == 17, k == 1 || k == 12, k == 11 || k == 20};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lengthen_tick%0d: got %b expected %b", k, obs, exp);
      end
    end
    resync_required = 1'b0;
  endtask

  task automatic test_shorten();
    logic [9:0] obs;
    logic [2:0] p;
    logic [2:0] exp;
    do_reset(4'd2, 4'd3, 4'd4);
    enable  = 1'b1;
    tq_tick = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
    checks++;
    if (obs !== {2'b11, 5'd2, 3'b000}) begin
      errors++;
      $display("FAIL shorten_pre: got %h expected %h", obs, {2'b11, 5'd2, 3'b000});
    end
    tq_tick           = 1'b0;
    resync_required   = 1'b1;
    resync_direction  = 1'b1;
    resync_adjustment = 4'd3;
    step();
    resync_required = 1'b0;
    obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
    checks++;
    if (obs !== {2'b11, 5'd2, 3'b000}) begin
      errors++;
      $display("FAIL shorten_accept: got %h expected %h", obs, {2'b11, 5'd2, 3'b000});
    end
    tq_tick = 1'b1;
    step();
    obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
    checks++;
    if (obs !== {2'b00, 5'd0, 3'b001}) begin
      errors++;
      $display("FAIL shorten_end: got %h expected %h", obs, {2'b00, 5'd0, 3'b001});
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      p   = {sample_point, transmit_point, bit_boundary};
      exp = {k == 6, k == 1, k == 10};
      checks++;
      if (p !== exp) begin
        errors++;
        $display("FAIL shorten_next_tick%0d: got %b expected %b", k, p, exp);
      end
    end
  endtask

  task automatic test_second_resync();
    logic [2:0] obs;
    logic [2:0] exp;
    do_reset(4'd2, 4'd3, 4'd3);
    enable  = 1'b1;
    tq_tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      resync_required   = (k == 2) || (k == 8);
      resync_direction  = (k == 8);
      resync_adjustment = (k == 8) ? 4'd2 : 4'd1;
      step();
      obs = {sample_point, transmit_point, bit_boundary};
      exp = {k == 7, k == 1 || k == 11, k == 10};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL second_resync_tick%0d: got %b expected %b", k, obs, exp);
      end
    end
    resync_required = 1'b0;
  endtask

  task automatic test_hard_sync();
    logic [9:0] obs;
    logic [2:0] p;
    logic [2:0] exp;
    do_reset(4'd2, 4'd3, 4'd3);
    enable  = 1'b1;
    tq_tick = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      hard_sync_request = (k == 5);
      resync_required   = (k == 5);
      resync_direction  = 1'b0;
      resync_adjustment = 4'd3;
      step();
      if (k == 5) begin
        obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
        checks++;
        if (obs !== 10'd0) begin
          errors++;
          $display("FAIL hard_sync_state: got %h expected %h", obs, 10'd0);
        end
      end
      p   = {sample_point, transmit_point, bit_boundary};
      exp = {k == 11, k == 1 || k == 6, k == 14};
      checks++;
      if (p !== exp) begin
        errors++;
        $display("FAIL hard_sync_tick%0d: got %b expected %b", k, p, exp);
      end
    end
    hard_sync_request = 1'b0;
    resync_required   = 1'b0;
  endtask

  task automatic test_enable_freeze();
    logic [9:0] obs;
    logic [2:0] p;
    logic [2:0] exp;
    do_reset(4'd2, 4'd3, 4'd3);
    enable  = 1'b1;
    tq_tick = 1'b1;
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hard_sync_request = (i == 2);
      resync_required   = (i == 3);
      resync_direction  = 1'b0;
      resync_adjustment = 4'd3;
      step();
      obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
      checks++;
      if (obs !== {2'b01, 5'd1, 3'b000}) begin
        errors++;
        $display("FAIL enable_hold%0d: got %h expected %h", i, obs, {2'b01, 5'd1, 3'b000});
      end
    end
    hard_sync_request = 1'b0;
    resync_required   = 1'b0;
    enable            = 1'b1;
    for (int k = 3; k <= 9; k++) begin
      step();
      if (k == 3) begin
        obs = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
        checks++;
        if (obs !== {2'b10, 5'd0, 3'b000}) begin
          errors++;
          $display("FAIL enable_resume: got %h expected %h", obs, {2'b10, 5'd0, 3'b000});
        end
      end
      p   = {sample_point, transmit_point, bit_boundary};
      exp = {k == 6, 1'b0, k == 9};
      checks++;
      if (p !== exp) begin
        errors++;
        $display("FAIL enable_tick%0d: got %b expected %b", k, p, exp);
      end
    end
  endtask

  task automatic test_reset_mid_bit();
    logic [6:0] obs;
    logic [9:0] full;
    do_reset(4'd2, 4'd3, 4'd3);
    enable  = 1'b1;
    tq_tick = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    reset_n = 1'b0;
    #2;
    obs = {current_segment, quanta_counter};
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, 7'd0);
    end
    step();
    reset_n = 1'b1;
    step();
    full = {current_segment, quanta_counter, sample_point, transmit_point, bit_boundary};
    checks++;
    if (full !== {2'b01, 5'd0, 3'b010}) begin
      errors++;
      $display("FAIL reset_restart: got %h expected %h", full, {2'b01, 5'd0, 3'b010});
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    enable            = 1'b0;
    tq_tick           = 1'b0;
    prop_seg          = 4'd2;
    phase_segment_1   = 4'd3;
    phase_segment_2   = 4'd3;
    hard_sync_request = 1'b0;
    resync_required   = 1'b0;
    resync_adjustment = 4'd0;
    resync_direction  = 1'b0;
    test_reset();
    test_nominal();
    test_zero_lengths();
    test_lengthen();
    test_shorten();
    test_second_resync();
    test_hard_sync();
    test_enable_freeze();
    test_reset_mid_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_timing_fsm.md
BIT_TIMING_FSM -- requirements
Module: bit_timing_fsm

Interface
REQ-001 The block SHALL have one clock and one reset. The reset SHALL be asynchronous and active-low. Ports SHALL be named clock and reset_n.
REQ-002 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  when 0, all state SHALL be frozen and all pulse outputs SHALL be 0.
REQ-005 tq_tick  input  1  one-cycle time-quantum strobe from the prescaler.
REQ-006 prop_seg  input  4  propagation segment length in tq; a value of 0 SHALL be treated as 1.
REQ-007 phase_segment_1  input  4  phase segment 1 length in tq; a value of 0 SHALL be treated as 1.
REQ-008 phase_segment_2  input  4  phase segment 2 length in tq; a value of 0 SHALL be treated as 1.
REQ-009 hard_sync_request  input  1  restarts the bit time.
REQ-010 resync_required  input  1  one-cycle resynchronisation request from the phase-error stage.
REQ-011 resync_adjustment  input  4  resynchronisation amount in tq, already clamped to SJW upstream.
REQ-012 resync_direction  input  1  0 = lengthen phase segment 1; 1 = shorten phase segment 2.
REQ-013 current_segment  output  2  segment code: 00 SYNC, 01 PROP, 10 PS1, 11 PS2.
REQ-014 quanta_counter  output  5  count of tq elapsed within the current segment, 0-based.
REQ-015 sample_point  output  1  one-cycle pulse on the tq_tick that ends PS1.
REQ-016 transmit_point  output  1  one-cycle pulse on the tq_tick that ends SYNC.
REQ-017 bit_boundary  output  1  one-cycle pulse on the tq_tick that ends PS2.

Function
REQ-018 Segment sequence SHALL be SYNC -> PROP -> PS1 -> PS2 -> SYNC. Transitions SHALL occur only on a cycle where tq_tick=1 and enable=1.
REQ-019 Segment lengths:
- SYNC SHALL last exactly 1 tq.
- PROP SHALL last prop_seg tq.
- PS1 SHALL last phase_segment_1 + ext1 tq, where ext1 is a 5-bit register.
- PS2 SHALL last max(phase_segment_2 - short2, quanta_counter+1) tq, where short2 is a 5-bit register.
- The PS2 subtraction SHALL saturate at 0 and SHALL never produce a length below 1.
REQ-020 On each tq_tick, quanta_counter SHALL increment. On the tick where quanta_counter == segment length - 1, the segment SHALL end: quanta_counter SHALL go to 0 and current_segment SHALL advance.
REQ-021 sample_point, transmit_point and bit_boundary SHALL be registered. Each SHALL assert in the cycle after its ending tick, together with the updated current_segment.
REQ-022 Resync acceptance:
- A resync_required pulse with enable=1 SHALL be accepted only when the resync_done flag is 0.
- Direction 0 SHALL be accepted only when current_segment is PROP or PS1; it SHALL load ext1 := resync_adjustment.
- Direction 1 SHALL be accepted only when current_segment is PS2; it SHALL load short2 := resync_adjustment.
- Any accepted resync SHALL set resync_done.
REQ-023 A resync request in SYNC, a wrong-direction request, and a request while resync_done=1 SHALL be ignored.
REQ-024 An adjustment accepted in a cycle SHALL first affect the length comparison in the following cycle. A tq_tick in the same cycle SHALL use the old length.
REQ-025 If a shortening leaves PS2 length <= quanta_counter+1, PS2 SHALL end on the next tq_tick.
REQ-026 On entry to SYNC, ext1, short2 and resync_done SHALL clear to 0.
REQ-027 Hard sync (hard_sync_request=1 with enable=1):
- Next cycle: current_segment=SYNC, quanta_counter=0, ext1=0, short2=0, resync_done=0, all pulses 0.
- Hard sync SHALL take priority over resync_required and tq_tick in the same cycle.
REQ-028 Inputs prop_seg, phase_segment_1 and phase_segment_2 SHALL be read live. Software SHALL change them only while enable=0. No glitch protection is required.
REQ-029 When enable=0: tq_tick, resync_required and hard_sync_request SHALL be ignored; current_segment and quanta_counter SHALL hold; all pulses SHALL be 0.

Reset
REQ-030 While reset_n=0, the following SHALL hold asynchronously: current_segment=00, quanta_counter=0, sample_point=0, transmit_point=0, bit_boundary=0, ext1=0, short2=0, resync_done=0.
REQ-031 Reset deassertion mid-bit SHALL restart from SYNC, with the first tq_tick ending SYNC.

Verification
REQ-032 Nominal bit: prop_seg=2, phase_segment_1=3, phase_segment_2=3, tq_tick every cycle.
- Bit period SHALL be 9 cycles.
- transmit_point SHALL occur after tick 1, sample_point after tick 6, bit_boundary after tick 9.
REQ-033 Lengthen: same configuration, resync_required=1, direction 0, adjustment 2, asserted in PROP.
- PS1 SHALL last 5 tq.
- sample_point SHALL occur after tick 8.
- That bit SHALL last 11 tq; the next bit SHALL last 9 tq.
REQ-034 Shorten: phase_segment_2=4; direction 1, adjustment 3, asserted in PS2 with quanta_counter=2.
- PS2 SHALL end on the next tq_tick.
- bit_boundary SHALL pulse and current_segment SHALL return to 00.
REQ-035 Second resync in the same bit (accepted direction 0 adjustment 1, then direction 1 adjustment 2 in PS2):
- The second request SHALL be ignored.
- PS2 SHALL keep its full length of 3 tq.
REQ-036 Hard sync in PS1 with quanta_counter=1, asserted in the same cycle as resync_required and tq_tick:
- Next cycle: current_segment=00, quanta_counter=0, no sample_point.
- The following bit SHALL last 9 tq.
REQ-037 enable=0 for 5 cycles in PROP with ticks present: outputs SHALL hold, with no pulses. On re-enable, timing SHALL resume from the held quanta_counter.
